// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM-style condition codes, CNVZ flag bit positions
// and the condition-check FSM state encoding.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } cc_state_t;

  // AL and NV do not depend on the flags, so they never wait on a producer.
  function automatic logic cond_is_flag_free(input logic [3:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/cond_decode.sv
// Combinational ARM condition-code evaluator over a {C,N,V,Z} flag nibble.
module cond_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_c;
  logic w_n;
  logic w_v;
  logic w_z;

  assign w_c = i_flags[FLAG_C];
  assign w_n = i_flags[FLAG_N];
  assign w_v = i_flags[FLAG_V];
  assign w_z = i_flags[FLAG_Z];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_check_unit.sv
// Condition check unit: evaluates a condition code against forwarded CNVZ flags,
// waits (bounded) on an in-flight flag producer, returns result over valid/ready.
module cond_check_unit
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Req_valid,
  output logic       Req_ready,
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  input  logic       Fw_valid,
  input  logic [3:0] Fw_flags,
  input  logic       Pend,
  output logic       Resp_valid,
  input  logic       Resp_ready,
  output logic       Cond_pass,
  output logic [3:0] Resp_flags,
  output logic       Timeout
);

  cc_state_t        r_state;
  cc_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cond;
  logic             r_pass;
  logic [3:0]       r_flags;
  logic             r_tmo;

  logic       w_ready;
  logic       w_accept;
  logic [3:0] w_eff;
  logic [3:0] w_dec_cond;
  logic       w_pass;
  logic       w_expire;
  logic       w_eval;
  logic       w_tmo;
  logic       w_start_wait;

  assign w_ready    = (r_state == ST_IDLE) || ((r_state == ST_RESP) && Resp_ready);
  assign w_accept   = Req_valid && w_ready;
  assign w_eff      = Fw_valid ? Fw_flags : Flags;
  assign w_dec_cond = (r_state == ST_WAIT) ? r_cond : Cond;
  assign w_expire   = (r_cnt == CNT_W'(MAX_WAIT - 1));

  cond_decode u_decode (
    .i_cond  (w_dec_cond),
    .i_flags (w_eff),
    .o_pass  (w_pass)
  );

  always_comb begin
    w_next       = r_state;
    w_eval       = 1'b0;
    w_tmo        = 1'b0;
    w_start_wait = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          // A pending producer wins over a same-cycle forward: its flags are newer.
          if (Pend && !cond_is_flag_free(Cond)) begin
            w_next       = ST_WAIT;
            w_start_wait = 1'b1;
          end else begin
            w_next = ST_RESP;
            w_eval = 1'b1;
          end
        end else if ((r_state == ST_RESP) && Resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!Pend) begin
          w_next = ST_RESP;
          w_eval = 1'b1;
        end else if (w_expire) begin
          w_next = ST_RESP;
          w_tmo  = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cond  <= '0;
      r_pass  <= 1'b0;
      r_flags <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_wait) begin
        r_cond <= Cond;
        r_cnt  <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_eval) begin
        r_pass  <= w_pass;
        r_flags <= w_eff;
        r_tmo   <= 1'b0;
      end else if (w_tmo) begin
        r_pass  <= 1'b0;
        r_flags <= Flags;
        r_tmo   <= 1'b1;
      end
    end
  end

  // Gated by reset so every output reads 0 while reset is asserted.
  assign Req_ready  = Reset_n && w_ready;
  assign Resp_valid = (r_state == ST_RESP);
  assign Cond_pass  = r_pass;
  assign Resp_flags = r_flags;
  assign Timeout    = r_tmo;

endmodule

// File: doc/cond_check_unit.md
Name: cond_check_unit

Overview:
Consumer side of the CNVZ flag register. It accepts a 4-bit ARM-style condition code from the issue stage and evaluates it against the architectural flags. A flag write landing this cycle is forwarded. When a flag-setting instruction is still in flight, the unit waits for it and times out after a bounded number of cycles. The registered pass/fail result is returned to the branch/predication logic over a valid/ready handshake.

Parameters:
MAX_WAIT, 8, maximum cycles spent waiting on a pending flag producer before a timeout response (1..255).
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
Clk  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
Req_valid  input  1  condition request present.
Req_ready  output  1  unit can accept a request this cycle.
Cond  input  4  condition code, sampled when Req_valid && Req_ready.
Flags  input  4  flag register output, ordered {C,N,V,Z} (bit3=C, bit2=N, bit1=V, bit0=Z).
Fw_valid  input  1  flag register is being loaded at the next edge (its Le is high).
Fw_flags  input  4  value being loaded, same {C,N,V,Z} order.
Pend  input  1  a flag-setting instruction is in flight and its flags are not yet on Fw_flags.
Resp_valid  output  1  result valid.
Resp_ready  input  1  downstream accepts the result.
Cond_pass  output  1  condition evaluated true.
Resp_flags  output  4  flag snapshot used for the evaluation.
Timeout  output  1  response produced by wait expiry; Cond_pass is forced to 0.

Behaviour:
- Effective flags: Fw_valid ? Fw_flags : Flags, sampled in the evaluating cycle.
- Condition table:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Req_ready=1.
  - On accept with Pend=0 (or Cond=E/F, which never wait): evaluate and latch Cond_pass, Resp_flags, Timeout=0, then go to RESP. Latency is 1 cycle.
  - On accept with Pend=1 and Cond not E/F: latch Cond, clear the counter, go to WAIT.
- WAIT:
  - Req_ready=0. The counter increments each cycle.
  - When Pend=0, evaluate the latched Cond against the effective flags that cycle, then go to RESP.
  - Else if the counter reaches MAX_WAIT-1: Cond_pass=0, Timeout=1, Resp_flags=Flags, go to RESP.
  - Pend falling in the same cycle as expiry: the evaluation wins and Timeout=0.
- RESP:
  - Resp_valid=1. Outputs are held stable while Resp_ready=0.
  - Req_ready = Resp_ready, so back-to-back operation is allowed.
  - Resp_ready=1 with no new request: go to IDLE.
  - Resp_ready=1 with a new request accepted: follow the IDLE acceptance rules (next RESP or WAIT).
  - Sustained throughput is 1 result per cycle when Pend=0.
- Reset (asynchronous, any state including mid-WAIT):
  - State goes to IDLE; counter, Resp_valid, Cond_pass, Resp_flags and Timeout go to 0.
  - Req_ready=1 after reset deasserts.
- Fw_valid and Pend both high: Pend takes priority (wait).
- Req_valid while Req_ready=0 is ignored; the requester holds it.

Decomposition:
- Shared package (cpu_pkg):
  - Condition-code constants COND_EQ..COND_NV.
  - Flag bit index constants FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0.
  - State enum for IDLE/WAIT/RESP.
- One combinational sub-module, cond_decode (Cond, flags -> pass), shared with any future predication logic.
- FSM, counter and output registers live in cond_check_unit.

Test Plan:
- Reset, then Cond=0 (EQ), Flags=4'b0001, Pend=0 -> next cycle Resp_valid=1, Cond_pass=1, Resp_flags=0001, Timeout=0.
- Cond=A (GE), Flags=4'b0100 (N=1,V=0), Fw_valid=1, Fw_flags=4'b0110 -> Cond_pass=1 (forwarded N=V), Resp_flags=0110.
- Cond=C (GT), Pend=1 for 3 cycles, then Pend=0 with Fw_valid=1, Fw_flags=0000 -> Req_ready=0 while waiting, response 1 cycle after Pend falls, Cond_pass=1.
- MAX_WAIT=4, Cond=9, Pend held high -> after 4 WAIT cycles Resp_valid=1, Timeout=1, Cond_pass=0.
- Resp_ready=0 for 5 cycles with Cond_pass=1 -> outputs stable, Req_ready=0, new Req_valid ignored; Resp_ready=1 together with Req_valid -> back-to-back second response.
- Reset_n pulled low mid-WAIT (asynchronously, between edges) -> all outputs 0 immediately; a new request after release is handled normally.
